muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, successor to the single-width combinational ALU HI/LO path. Sits beside the execute-stage ALU: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, stalls the pipeline while iterating, and owns HI/LO so that MFHI/MFLO read them directly. Divide runs as a restoring iteration. Multiply is iterative or single-cycle per build option.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_div_core.sv | 77 +++++++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op encodings carried on muldiv_if.op
//   - FSM state type and state constants
//   - result-select type choosing what (if anything) is written to HI/LO
//   - small op-decode helpers
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_NOP7  = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef enum logic [2:0] {SelNone, SelHi, SelLo, SelMul, SelDiv} res_sel_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the execute stage and muldiv_unit.
//   master (issuer): drives flush, start, op, a, b; observes busy, done, hi, lo.
//   slave  (unit)  : the reverse.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring-divide datapath on unsigned magnitudes.
//   clk, rst      : clock, async active-low reset
//   load_i        : capture dividend_i/divisor_i, clear remainder, counter <- WIDTH-1
//   step_i        : perform one restoring step and decrement the counter
//   dividend_i    : dividend magnitude
//   divisor_i     : divisor magnitude
//   quotient_o    : quotient after the step taken this cycle
//   remainder_o   : remainder after the step taken this cycle
//   last_o        : counter is 0, i.e. this step is the final one
// The counter also paces the iterative multiplier in the parent.
module muldiv_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             last_o
);
    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] step_rem;

    always_comb begin
        // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
        partial  = {rem_q, quo_q[WIDTH-1]};
        trial    = partial - {1'b0, dvs_q};
        // partial < 2*divisor, so a set MSB of trial can only mean a borrow.
        step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        step_rem = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];

        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = CntW'(WIDTH - 1);
        end else if (step_i) begin
            quo_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o  = step_quo;
    assign remainder_o = step_rem;
    assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning architectural HI/LO.
//   clk, rst : clock, async active-low reset (clears HI/LO)
//   mdu      : muldiv_if.slave -- flush/start/op/a/b in; busy/done/hi/lo out
// Divide is a WIDTH-step restoring iteration on magnitudes with sign fix-up.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply
// (IDLE -> DONE directly); otherwise a WIDTH-step shift-add multiply.
// The interface instance must be built with the same WIDTH as this module.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    mdu
);
`ifdef MULDIV_FAST_MUL_EN
    localparam bit     FastMul  = 1'b1;
    localparam state_t MulEntry = ST_DONE;
`else
    localparam bit     FastMul  = 1'b0;
    localparam state_t MulEntry = ST_MUL;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;
    logic               idle_like, accept, issue_mul, issue_div, iterating;
    logic               op_signed, neg_now, mul_neg, last;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_step, rem_step;
    logic [2*WIDTH-1:0] mul_res;
    res_sel_e           sel;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = idle_like & mdu.start & ~mdu.flush;
    assign issue_mul = accept & is_mul_op(mdu.op);
    assign issue_div = accept & is_div_op(mdu.op);
    assign iterating = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign op_signed = is_signed_op(mdu.op);
    assign mag_a     = (op_signed && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
    assign mag_b     = (op_signed && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;
    // Divide by zero keeps the raw all-ones quotient, so its sign is never flipped.
    assign neg_now   = op_signed & (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1])
                       & (is_mul_op(mdu.op) | (|mdu.b));

`ifdef MULDIV_FAST_MUL_EN
    assign mul_res = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    assign mul_neg = neg_now;
`else
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     mul_sum;

    // prod holds {partial sum, unconsumed multiplier bits}; one LSB consumed per step.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_res = {mul_sum, prod_q[WIDTH-1:1]};
        prod_d  = prod_q;
        mcand_d = mcand_q;
        if (issue_mul) begin
            prod_d  = {{WIDTH{1'b0}}, mag_b};
            mcand_d = mag_a;
        end else if (state_q == ST_MUL) begin
            prod_d  = mul_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end

    assign mul_neg = neg_q;
`endif

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .load_i      (issue_mul | issue_div),
        .step_i      (iterating),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (quo_step),
        .remainder_o (rem_step),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (issue_div)      state_d = ST_DIV;
                else if (issue_mul) state_d = MulEntry;
                else                state_d = ST_IDLE;
            end
            ST_MUL, ST_DIV: begin
                if (mdu.flush) state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        neg_d  = (issue_mul | issue_div) ? neg_now : neg_q;
        rneg_d = (issue_mul | issue_div) ? (op_signed & mdu.a[WIDTH-1]) : rneg_q;

        sel = SelNone;
        if (accept) begin
            if (mdu.op == OP_MTHI)                     sel = SelHi;
            else if (mdu.op == OP_MTLO)                sel = SelLo;
            else if (FastMul && is_mul_op(mdu.op))     sel = SelMul;
        end else if (!mdu.flush && last) begin
            if (state_q == ST_MUL)                     sel = SelMul;
            else if (state_q == ST_DIV)                sel = SelDiv;
        end

        hi_d = hi_q;
        lo_d = lo_q;
        case (sel)
            SelHi:  hi_d = mdu.a;
            SelLo:  lo_d = mdu.a;
            SelMul: {hi_d, lo_d} = mul_neg ? -mul_res : mul_res;
            SelDiv: begin
                lo_d = neg_q  ? -quo_step : quo_step;
                hi_d = rneg_q ? -rem_step : rem_step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign mdu.busy = iterating
                      | (mdu.start & (is_mul_op(mdu.op) | is_div_op(mdu.op)) & idle_like);
    assign mdu.done = (state_q == ST_DONE);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors plus hand-written corner sequences.
// Expected HI/LO pairs are queued at issue and popped when done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    muldiv_if #(.WIDTH(WIDTH)) mdu ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] hilo;
        string       name;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    vec_t        vecs[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sbv, sq, sr;
        logic        [63:0] ua, ub, uq, ur;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (op)
            OP_MULT:  return sa * sbv;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                sq = sa / sbv;
                sr = sa % sbv;
                return {sr[31:0], sq[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Called at a negedge; drives one start cycle and returns at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu.start = 1'b1;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
        #1;
        check("busy_on_issue", 64'(mdu.busy), 64'(is_mul_op(op) | is_div_op(op)));
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.op    = OP_NOP;
    endtask

    // Waits (bounded) for done; start_cyc is the cycle index relative to the issue cycle.
    task automatic wait_done(input int lat, input int start_cyc, input bit once,
                             input string name);
        int   cyc      = start_cyc;
        int   busy_cyc = 0;
        bit   seen     = 1'b0;
        exp_t e;
        while (cyc <= lat + 4) begin
            if (mdu.done) begin
                seen = 1'b1;
                break;
            end
            if (mdu.busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_latency"}, 64'(cyc), 64'(lat));
        check({name, "_busy_cycles"}, 64'(busy_cyc), 64'(lat - start_cyc));
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard: got done, expected empty queue", name);
        end else begin
            e = exp_q.pop_front();
            check({e.name, "_hi"}, 64'(mdu.hi), 64'(e.hilo[63:32]));
            check({e.name, "_lo"}, 64'(mdu.lo), 64'(e.hilo[31:0]));
            model_hi = e.hilo[63:32];
            model_lo = e.hilo[31:0];
        end
        if (once) begin
            @(negedge clk);
            check({name, "_done_one_cycle"}, 64'(mdu.done), 64'd0);
        end
    endtask

    task automatic push_exp(input logic [63:0] hilo, input string name);
        exp_t e;
        e.hilo = hilo;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic no_done_for(input int n, input string name);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mdu.done) hits++;
        end
        check({name, "_no_done"}, 64'(hits), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   lat;

        vecs.push_back('{OP_DIVU,  32'd100,        32'd7,          {32'd2,        32'd14}});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}});
        vecs.push_back('{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000}});
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1});
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{OP_DIVU,  32'h0000_1234,  32'h0,          {32'h0000_1234, 32'hFFFF_FFFF}});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFFB,  32'h0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF}});
        vecs.push_back('{OP_MULT,  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000});
        vecs.push_back('{OP_MULT,  32'd7,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFF9});
        vecs.push_back('{OP_DIV,   32'd7,          32'hFFFF_FFFE,  {32'd1,        32'hFFFF_FFFD}});
        vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF,  32'h10,         {32'hF,        32'h0FFF_FFFF}});
        for (int i = 0; i < 8; i++) begin
            v.op  = 3'($urandom_range(1, 4));
            v.a   = $urandom;
            v.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            v.exp = model(v.op, v.a, v.b);
            vecs.push_back(v);
        end

        mdu.flush = 1'b0;
        mdu.start = 1'b0;
        mdu.op    = OP_NOP;
        mdu.a     = '0;
        mdu.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(mdu.busy), 64'd0);
        check("reset_done", 64'(mdu.done), 64'd0);
        check("reset_hi", 64'(mdu.hi), 64'd0);
        check("reset_lo", 64'(mdu.lo), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            lat = is_mul_op(vecs[i].op) ? MUL_LAT : DIV_LAT;
            push_exp(vecs[i].exp, $sformatf("vec%0d", i));
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, 1, 1'b1, $sformatf("vec%0d", i));
        end

        // MTHI then MTLO on consecutive cycles: no stall, visible after the edge.
        mdu.start = 1'b1;
        mdu.op    = OP_MTHI;
        mdu.a     = 32'hA5A5_A5A5;
        #1 check("mthi_busy", 64'(mdu.busy), 64'd0);
        @(negedge clk);
        mdu.op = OP_MTLO;
        mdu.a  = 32'h5A5A_5A5A;
        #1 check("mtlo_busy", 64'(mdu.busy), 64'd0);
        check("mthi_hi", 64'(mdu.hi), 64'hA5A5_A5A5);
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.op    = OP_NOP;
        check("mtlo_lo", 64'(mdu.lo), 64'h5A5A_5A5A);
        check("mtlo_hi_kept", 64'(mdu.hi), 64'hA5A5_A5A5);
        check("mt_done", 64'(mdu.done), 64'd0);
        model_hi = 32'hA5A5_A5A5;
        model_lo = 32'h5A5A_5A5A;

        // Flush mid-divide: back to IDLE next edge, no done, HI/LO untouched.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.flush = 1'b0;
        check("flush_idle_busy", 64'(mdu.busy), 64'd0);
        no_done_for(DIV_LAT + 4, "flush_mid");
        check("flush_mid_hi", 64'(mdu.hi), 64'(model_hi));
        check("flush_mid_lo", 64'(mdu.lo), 64'(model_lo));

        // Flush with start in the same cycle drops the op, including MTHI.
        mdu.start = 1'b1;
        mdu.op    = OP_DIVU;
        mdu.a     = 32'd9;
        mdu.b     = 32'd3;
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.op = OP_MTHI;
        mdu.a  = 32'hDEAD_BEEF;
        check("flush_start_busy", 64'(mdu.busy & ~mdu.start), 64'd0);
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.flush = 1'b0;
        mdu.op    = OP_NOP;
        check("flush_start_idle", 64'(mdu.busy), 64'd0);
        check("flush_mthi_hi", 64'(mdu.hi), 64'(model_hi));
        no_done_for(DIV_LAT + 4, "flush_start");
        check("flush_start_lo", 64'(mdu.lo), 64'(model_lo));

        // A start while busy is ignored: result and latency belong to the first op.
        push_exp({32'd2, 32'd14}, "ignore_start");
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = OP_MULTU;
        mdu.a     = 32'd3;
        mdu.b     = 32'd5;
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.op    = OP_NOP;
        wait_done(DIV_LAT, 6, 1'b1, "ignore_start");

        // Back-to-back: a start in the DONE cycle is accepted.
        push_exp({32'd2, 32'd14}, "b2b_first");
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(DIV_LAT, 1, 1'b0, "b2b_first");
        push_exp(64'd15, "b2b_second");
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done(MUL_LAT, 1, 1'b1, "b2b_second");

        // Reset mid-divide clears HI/LO and busy immediately.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_hi", 64'(mdu.hi), 64'd0);
        check("rst_mid_lo", 64'(mdu.lo), 64'd0);
        check("rst_mid_busy", 64'(mdu.busy), 64'd0);
        check("rst_mid_done", 64'(mdu.done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_exp(64'hFFFF_FFFF_FFFF_FFF1, "after_rst");
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(MUL_LAT, 1, 1'b1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
